// File: rtl/icap_bitstream_packer.sv
// Byte-stream front end for the ICAP controller: finds the sync word, then packs
// bytes big-endian into 32-bit words and hands them out as one-cycle write strobes.
module icap_bitstream_packer #(
    parameter bit          BIT_SWAP  = 1'b1,
    parameter logic [31:0] SYNC_WORD = 32'hAA995566,
    parameter int          CNT_W     = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic             icap_busy,
    output logic [31:0]      icap_data,
    output logic             icap_write,
    output logic             sync_found,
    output logic             done,
    output logic             err_nosync,
    output logic             err_partial,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [2:0] {HUNT, PACK, FLUSH, DRAIN, DONE} state_t;

    state_t      state;
    logic [31:0] shreg;
    logic [31:0] word;
    logic [31:0] pend_word;
    logic        pend;
    logic [1:0]  idx;

    logic        accept;
    logic        issue;
    logic [31:0] shift_next;
    logic [31:0] word_next;

    function automatic logic [7:0] swap_byte(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (BIT_SWAP) begin
            for (int i = 0; i < 8; i++) r[i] = b[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] swap_word(input logic [31:0] w);
        return {swap_byte(w[31:24]), swap_byte(w[23:16]), swap_byte(w[15:8]), swap_byte(w[7:0])};
    endfunction

    assign accept     = s_valid && s_ready;
    assign issue      = pend && !icap_busy;
    assign shift_next = {shreg[23:0], s_data};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            HUNT:    s_ready = 1'b1;
            PACK:    s_ready = !(pend && idx == 2'd3);
            default: s_ready = 1'b0;
        endcase
    end

    // Starting a fresh word clears it, so a short tail is already zero-padded.
    always_comb begin
        word_next = (idx == 2'd0) ? 32'h0 : word;
        case (idx)
            2'd0: word_next[31:24] = swap_byte(s_data);
            2'd1: word_next[23:16] = swap_byte(s_data);
            2'd2: word_next[15:8]  = swap_byte(s_data);
            2'd3: word_next[7:0]   = swap_byte(s_data);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; a later load of
    // pend overrides the issue-clear above it, so a word can enter as one leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            shreg       <= 32'h0;
            word        <= 32'h0;
            pend_word   <= 32'h0;
            pend        <= 1'b0;
            idx         <= 2'd0;
            icap_data   <= 32'h0;
            icap_write  <= 1'b0;
            sync_found  <= 1'b0;
            done        <= 1'b0;
            err_nosync  <= 1'b0;
            err_partial <= 1'b0;
            word_count  <= '0;
        end else begin
            icap_write <= issue;
            if (issue) begin
                icap_data <= pend_word;
                pend      <= 1'b0;
            end
            if (icap_write && word_count != '1) word_count <= word_count + CNT_W'(1);

            case (state)
                HUNT: if (accept) begin
                    shreg <= shift_next;
                    if (shift_next == SYNC_WORD) begin
                        sync_found <= 1'b1;
                        pend_word  <= swap_word(SYNC_WORD);
                        pend       <= 1'b1;
                        idx        <= 2'd0;
                        state      <= s_last ? DRAIN : PACK;
                    end else if (s_last) begin
                        err_nosync <= 1'b1;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                PACK: if (accept) begin
                    word <= word_next;
                    if (idx == 2'd3) begin
                        pend_word <= word_next;
                        pend      <= 1'b1;
                        idx       <= 2'd0;
                        if (s_last) state <= DRAIN;
                    end else if (s_last) begin
                        err_partial <= 1'b1;
                        idx         <= 2'd0;
                        if (!pend) begin
                            pend_word <= word_next;
                            pend      <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                FLUSH: if (!pend) begin
                    pend_word <= word;
                    pend      <= 1'b1;
                    state     <= DRAIN;
                end
                DRAIN: if (!pend && !icap_write) begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icap_bitstream_packer.sv
// Directed bench for icap_bitstream_packer: one swapping and one non-swapping
// instance share the same stimulus; written words are captured and compared.
module tb_icap_bitstream_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        icap_busy = 1'b0;

    logic        a_ready, a_write, a_sync, a_done, a_nosync, a_partial;
    logic [31:0] a_data;
    logic [23:0] a_count;
    logic        b_ready, b_write, b_sync, b_done, b_nosync, b_partial;
    logic [31:0] b_data;
    logic [23:0] b_count;

    icap_bitstream_packer #(.BIT_SWAP(1'b1)) dut_swap (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(a_ready), .icap_busy(icap_busy), .icap_data(a_data), .icap_write(a_write),
        .sync_found(a_sync), .done(a_done), .err_nosync(a_nosync), .err_partial(a_partial),
        .word_count(a_count)
    );

    icap_bitstream_packer #(.BIT_SWAP(1'b0)) dut_noswap (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(b_ready), .icap_busy(icap_busy), .icap_data(b_data), .icap_write(b_write),
        .sync_found(b_sync), .done(b_done), .err_nosync(b_nosync), .err_partial(b_partial),
        .word_count(b_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          stall_seen = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] exp_q[$];
    logic [7:0]  stim[$];

    always @(negedge clk) begin
        if (a_write) qa.push_back(a_data);
        if (b_write) qb.push_back(b_data);
        if (s_valid && !a_ready) stall_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        stall_seen = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        logic ok;
        int   guard;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        guard   = 0;
        forever begin
            ok = a_ready;
            @(negedge clk);
            if (ok) break;
            guard++;
            if (guard > 200) begin
                check("send_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_byte(stim[i], i == stim.size() - 1);
    endtask

    task automatic send_sync();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!(a_done && b_done) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, {30'd0, b_done, a_done}, 32'd3);
    endtask

    task automatic check_words(input bit use_b, input string tag);
        logic [31:0] got;
        int          n;
        n = use_b ? qb.size() : qa.size();
        check({tag, "_nwords"}, 32'(n), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            got = 32'hDEADBEEF;
            if (i < n) got = use_b ? qb[i] : qa[i];
            check($sformatf("%s_w%0d", tag, i), got, exp_q[i]);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_ready", {31'd0, a_ready}, 32'd1);
        check("rst_data", a_data, 32'h0);
        check("rst_flags", {27'd0, a_write, a_sync, a_done, a_nosync, a_partial}, 32'h0);
        check("rst_count", {8'd0, a_count}, 32'd0);

        // Basic pack, both swap settings on the same stream
        stim = '{8'h00, 8'hAA, 8'h99, 8'h55, 8'h66, 8'h20, 8'h00, 8'h00, 8'h00};
        send_stim();
        wait_done("basic");
        exp_q = '{32'h5599AA66, 32'h04000000};
        check_words(1'b0, "basic_swap");
        exp_q = '{32'hAA995566, 32'h20000000};
        check_words(1'b1, "basic_noswap");
        check("basic_count", {8'd0, a_count}, 32'd2);
        check("basic_count_b", {8'd0, b_count}, 32'd2);
        check("basic_flags", {28'd0, a_sync, a_done, a_nosync, a_partial}, 32'b1100);

        // Busy backpressure across 12 data bytes
        do_reset();
        send_sync();
        icap_busy = 1'b1;
        fork
            begin
                for (int i = 1; i <= 12; i++) send_byte(8'(i), i == 12);
            end
            begin
                repeat (10) @(negedge clk);
                check("busy_no_write", 32'(qa.size()), 32'd0);
                icap_busy = 1'b0;
            end
        join
        wait_done("busy");
        check("busy_stall_seen", {31'd0, stall_seen > 0}, 32'd1);
        exp_q = '{32'h5599AA66, 32'h8040C020, 32'hA060E010, 32'h9050D030};
        check_words(1'b0, "busy");
        check("busy_count", {8'd0, a_count}, 32'd4);
        check("busy_partial", {31'd0, a_partial}, 32'd0);

        // Partial tail with the pending register free
        do_reset();
        send_sync();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_done("partial");
        exp_q = '{32'h5599AA66, 32'h88440000};
        check_words(1'b0, "partial");
        check("partial_flags", {28'd0, a_sync, a_done, a_nosync, a_partial}, 32'b1101);
        check("partial_count", {8'd0, a_count}, 32'd2);

        // Partial tail while the sync word is still pending (goes through FLUSH)
        do_reset();
        send_sync();
        icap_busy = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        repeat (3) @(negedge clk);
        check("flush_ready", {31'd0, a_ready}, 32'd0);
        check("flush_held", 32'(qa.size()), 32'd0);
        icap_busy = 1'b0;
        wait_done("flush");
        exp_q = '{32'h5599AA66, 32'h88440000};
        check_words(1'b0, "flush");
        check("flush_partial", {31'd0, a_partial}, 32'd1);

        // No sync word in the stream
        do_reset();
        stim = '{16{8'hFF}};
        send_stim();
        wait_done("nosync");
        check("nosync_flags", {28'd0, a_sync, a_done, a_nosync, a_partial}, 32'b0110);
        check("nosync_count", {8'd0, a_count}, 32'd0);
        check("nosync_writes", 32'(qa.size()), 32'd0);

        // Reset while a word is pending under busy
        do_reset();
        send_sync();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        icap_busy = 1'b1;
        send_byte(8'h04, 1'b0);
        repeat (2) @(negedge clk);
        check("pre_rst_count", {8'd0, a_count}, 32'd1);
        check("pre_rst_data", a_data, 32'h5599AA66);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_data", a_data, 32'h0);
        check("midrst_flags", {27'd0, a_write, a_sync, a_done, a_nosync, a_partial}, 32'h0);
        check("midrst_count", {8'd0, a_count}, 32'd0);
        check("midrst_ready", {31'd0, a_ready}, 32'd1);
        rst_n = 1'b1;
        icap_busy = 1'b0;
        qa.delete();
        qb.delete();
        stim = '{8'h00, 8'hAA, 8'h99, 8'h55, 8'h66, 8'h20, 8'h00, 8'h00, 8'h00};
        send_stim();
        wait_done("after_rst");
        exp_q = '{32'h5599AA66, 32'h04000000};
        check_words(1'b0, "after_rst");
        check("after_rst_count", {8'd0, a_count}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icap_bitstream_packer.md
# icap_bitstream_packer

Upstream feeder for the ICAP controller. It accepts a raw partial-bitstream byte stream with a valid/ready handshake and hunts for the configuration sync word. From the sync word onward it packs bytes big-endian into 32-bit words, optionally bit-swapping each byte, and issues one-cycle write strobes to the ICAP stage, holding off whenever `icap_busy` is high. It also reports completion, error flags and a count of words written.

## Interface
Parameters:
- `BIT_SWAP`, 1: when 1, reverse bit order within each byte of every output word; when 0, pass bytes unchanged.
- `SYNC_WORD`, 32'hAA995566: raw (pre-swap) sync pattern that is searched for in the byte stream.
- `CNT_W`, 24: width of `word_count`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_data`  in  8  bitstream byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_last`  in  1  final byte of the bitstream; qualified by `s_valid`.
- `s_ready`  out  1  the byte is accepted on a cycle where `s_valid && s_ready`.
- `icap_busy`  in  1  ICAP stage cannot take a word.
- `icap_data`  out  32  word presented to the ICAP stage.
- `icap_write`  out  1  one-cycle strobe; `icap_data` is valid on this cycle.
- `sync_found`  out  1  sticky; sync word has been detected.
- `done`  out  1  sticky; stream ended and all words have been written.
- `err_nosync`  out  1  sticky; `s_last` arrived before any sync word.
- `err_partial`  out  1  sticky; `s_last` arrived mid-word and the word was zero-padded.
- `word_count`  out  `CNT_W`  number of `icap_write` pulses; saturates at all-ones.

## Operation
- States: HUNT, PACK, FLUSH, DRAIN, DONE. Reset enters HUNT.
- **HUNT**
  - `s_ready` = 1.
  - Each accepted byte shifts into a 32-bit raw shift register, with the newest byte in [7:0].
  - When the updated register equals `SYNC_WORD`: set `sync_found`, load `SYNC_WORD` (swapped if enabled) into the pending-word register, and set `pend`.
    - Next state is PACK, or DRAIN if the same byte has `s_last`.
  - Bytes before the sync word are discarded and never written.
  - `s_last` without a match: set `err_nosync`; go to DONE; no writes occur.
- **PACK**
  - Byte index `idx` runs 0..3. Byte `idx` lands in word bits [31-8*idx -: 8], swapped per `BIT_SWAP`.
  - `s_ready` = !(`pend` && `idx`==3).
  - Accepting byte `idx`=3 moves the assembled word to the pending register, sets `pend`, and resets `idx` to 0.
  - `s_last` with the word complete: go to DRAIN.
  - `s_last` with `idx` != 3: unfilled bytes become 0x00 and `err_partial` is set.
    - If `pend` is clear, the padded word goes to pending and the next state is DRAIN.
    - Otherwise go to FLUSH.
- **FLUSH**
  - `s_ready` = 0.
  - When `pend` clears, load the padded word into pending and go to DRAIN.
- **DRAIN**
  - `s_ready` = 0.
  - When `pend` is clear and `icap_write` is 0, go to DONE.
- **DONE**
  - `s_ready` = 0; `done` = 1. The block holds here until reset.
- **Issue rule**
  - On each edge: if `pend && !icap_busy`, then `icap_data` <= pending word, `icap_write` <= 1, and `pend` is cleared.
  - Otherwise `icap_write` <= 0 and `icap_data` holds its value.
  - A new word may enter pending on the same edge that the old one issues.
- `word_count` increments on every edge where `icap_write` is 1, and stops incrementing at 2^`CNT_W`-1.
- The sticky flags clear only on reset.

## Timing
- Reset (`rst_n`=0 at an edge): all outputs 0 (`icap_data`, `icap_write`, `sync_found`, `done`, both error flags, `word_count`). `pend` = 0, `idx` = 0, state = HUNT.
  - After reset, `s_ready` = 1 because the state is HUNT.
  - Reset mid-stream discards the accumulated and pending words.
  - Any `icap_write` pulse ends at that edge.
- Latency: a word completed by the byte accepted in cycle N has `pend` set at edge N+1. `icap_write` is high in cycle N+2 if `icap_busy` is low in cycle N+1.
- Throughput is one byte per cycle while `icap_busy` stays low. Bytes 0-2 of the next word are always accepted while `pend` is set.
- `icap_busy` high stalls only the completion of the next word. No word is ever dropped or duplicated.
- `done` rises one edge after the final `icap_write` pulse ends.

## Test plan
- **Basic pack with swap:** reset, then bytes 00 AA 99 55 66 20 00 00 00 with `s_last` on the final byte, `BIT_SWAP`=1, busy low.
  - Expect `icap_write` pulses carrying 0x5599AA66 then 0x04000000.
  - Expect `word_count`=2, `sync_found`=1, `done`=1, and no error flags.
- **No swap:** same stream with `BIT_SWAP`=0.
  - Expect words 0xAA995566 then 0x20000000.
- **Busy backpressure:** hold `icap_busy`=1 for 10 cycles after the sync word completes, while streaming 12 data bytes.
  - `s_ready` drops once `idx`=3 with a word pending.
  - After busy releases, exactly 4 words emerge in order with no loss.
- **Partial tail:** after sync, send bytes 11 22 with `s_last`.
  - Expect final word 0x88440000 with swap enabled, `err_partial`=1 and `done`=1.
- **No sync:** send 16 bytes of 0xFF with `s_last`.
  - Expect `err_nosync`=1, `done`=1, `word_count`=0, and `icap_write` never asserted.
- **Reset mid-operation:** assert `rst_n`=0 while a word is pending and busy is high.
  - Expect all outputs 0 at the next edge.
  - A fresh stream afterwards packs correctly from HUNT.
